// File: rtl/alu_arbiter_if.sv
// Bundle of requester, response and ALU-side signals for alu_arbiter.
// The arbiter connects as slave; requesters, responders and the ALU sit on the master side.
interface alu_arbiter_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AFW   = 4,
    parameter int unsigned CNTW  = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [AFW-1:0]   req0_af;
    logic             req0_i;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [AFW-1:0]   req1_af;
    logic             req1_i;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_res;
    logic             rsp_zero;
    logic             rsp_neg;
    logic             rsp_ovf;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [AFW-1:0]   af;
    logic             i;
    logic [WIDTH-1:0] Alures;
    logic             Zero;
    logic             Neg;
    logic             ovfalu;
    logic             busy;
    logic [CNTW-1:0]  ovf_cnt;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_af, req0_i,
        input  req1_valid, req1_a, req1_b, req1_af, req1_i,
        input  rsp0_ready, rsp1_ready,
        input  Alures, Zero, Neg, ovfalu,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp_res, rsp_zero, rsp_neg, rsp_ovf,
        output SrcA, SrcB, af, i, busy, ovf_cnt
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_af, req0_i,
        output req1_valid, req1_a, req1_b, req1_af, req1_i,
        output rsp0_ready, rsp1_ready,
        output Alures, Zero, Neg, ovfalu,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp_res, rsp_zero, rsp_neg, rsp_ovf,
        input  SrcA, SrcB, af, i, busy, ovf_cnt
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters,
// one operation in flight: accept (IDLE) -> drive ALU (EXEC) -> respond (DONE).
module alu_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AFW   = 4,
    parameter int unsigned CNTW  = 8
) (
    input logic          clk,
    input logic          reset,
    alu_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] srca_q, srca_d;
    logic [WIDTH-1:0] srcb_q, srcb_d;
    logic [AFW-1:0]   af_q, af_d;
    logic             i_q, i_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             grant0, grant1;

    // On a tie the requester that did not win last time is granted.
    assign grant0 = (state_q == IDLE) && bus.req0_valid && (!bus.req1_valid || last_q);
    assign grant1 = (state_q == IDLE) && bus.req1_valid && (!bus.req0_valid || !last_q);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        srca_d  = srca_q;
        srcb_d  = srcb_q;
        af_d    = af_q;
        i_d     = i_q;
        res_d   = res_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    owner_d = grant1;
                    last_d  = grant1;
                    if (grant1) begin
                        srca_d = bus.req1_a;
                        srcb_d = bus.req1_b;
                        af_d   = bus.req1_af;
                        i_d    = bus.req1_i;
                    end else begin
                        srca_d = bus.req0_a;
                        srcb_d = bus.req0_b;
                        af_d   = bus.req0_af;
                        i_d    = bus.req0_i;
                    end
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d  = bus.Alures;
                zero_d = bus.Zero;
                neg_d  = bus.Neg;
                ovf_d  = bus.ovfalu;
                if (bus.ovfalu && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CNTW'(1);
                end
                state_d = DONE;
            end
            DONE: begin
                if (owner_q ? bus.rsp1_ready : bus.rsp0_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            srca_q  <= '0;
            srcb_q  <= '0;
            af_q    <= '0;
            i_q     <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            srca_q  <= srca_d;
            srcb_q  <= srcb_d;
            af_q    <= af_d;
            i_q     <= i_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp0_valid = (state_q == DONE) && !owner_q;
    assign bus.rsp1_valid = (state_q == DONE) && owner_q;
    assign bus.rsp_res    = res_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_neg    = neg_q;
    assign bus.rsp_ovf    = ovf_q;
    assign bus.SrcA       = srca_q;
    assign bus.SrcB       = srcb_q;
    assign bus.af         = af_q;
    assign bus.i          = i_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.ovf_cnt    = cnt_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU drives the DUT's ALU side,
// a model predicts grants and responses, a monitor checks responses as they appear.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;

    alu_arbiter_if #(.WIDTH(32), .AFW(4), .CNTW(8)) bus ();
    alu_arbiter_if #(.WIDTH(32), .AFW(4), .CNTW(2)) bus2 ();

    alu_arbiter #(.WIDTH(32), .AFW(4), .CNTW(8)) dut (.clk(clk), .reset(reset), .bus(bus));
    alu_arbiter #(.WIDTH(32), .AFW(4), .CNTW(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    // Toy ALU: add, sub, and, or, xor, pass-A; immediate select zero-extends B[15:0].
    function automatic logic [34:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] f, input logic im);
        logic [31:0] bb;
        logic [31:0] r;
        logic        o;
        bb = im ? {16'h0, b[15:0]} : b;
        o  = 1'b0;
        case (f)
            4'd0: begin r = a + bb; o = (a[31] == bb[31]) && (r[31] != a[31]); end
            4'd2: begin r = a - bb; o = (a[31] != bb[31]) && (r[31] != a[31]); end
            4'd4: r = a & bb;
            4'd5: r = a | bb;
            4'd6: r = a ^ bb;
            default: r = a;
        endcase
        return {o, r[31], (r == 32'h0), r};
    endfunction

    assign {bus.ovfalu, bus.Neg, bus.Zero, bus.Alures} = alu_f(bus.SrcA, bus.SrcB, bus.af, bus.i);
    assign {bus2.ovfalu, bus2.Neg, bus2.Zero, bus2.Alures} = alu_f(bus2.SrcA, bus2.SrcB, bus2.af, bus2.i);

    typedef struct {
        logic        own;
        logic [31:0] res;
        logic        z;
        logic        n;
        logic        o;
        logic [7:0]  cnt;
        int unsigned due;
    } exp_t;

    exp_t       q[$];
    logic       last_m = 1'b1;
    logic [7:0] cnt_m = 8'h0;
    logic       acc0 = 1'b0;
    logic       acc1 = 1'b0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Reference model: arbitration decision and expected response, pushed on accept.
    initial forever begin : model
        logic v0, v1, e0, e1, free;
        logic [34:0] r;
        exp_t e;
        @(negedge clk);
        cyc++;
        if (reset) begin
            q.delete();
            last_m = 1'b1;
            cnt_m  = 8'h0;
            acc0   = 1'b0;
            acc1   = 1'b0;
        end else begin
            free = (q.size() == 0);
            v0 = bus.req0_valid;
            v1 = bus.req1_valid;
            e0 = free && v0 && (!v1 || last_m);
            e1 = free && v1 && (!v0 || !last_m);
            chk("req0_ready", bus.req0_ready, e0);
            chk("req1_ready", bus.req1_ready, e1);
            chk("busy", bus.busy, !free);
            if (e0 || e1) begin
                r = e1 ? alu_f(bus.req1_a, bus.req1_b, bus.req1_af, bus.req1_i)
                       : alu_f(bus.req0_a, bus.req0_b, bus.req0_af, bus.req0_i);
                if (r[34] && cnt_m != 8'hFF) cnt_m++;
                e.own = e1; e.res = r[31:0]; e.z = r[32]; e.n = r[33]; e.o = r[34];
                e.cnt = cnt_m; e.due = cyc + 2;
                q.push_back(e);
                last_m = e1;
            end
            acc0 = e0;
            acc1 = e1;
        end
    end

    // Monitor: compares presented responses against the scoreboard head.
    initial forever begin : monitor
        exp_t e;
        @(negedge clk);
        #1;
        if (!reset) begin
            if (q.size() > 0 && cyc >= q[0].due) begin
                e = q[0];
                chk("rsp0_valid", bus.rsp0_valid, !e.own);
                chk("rsp1_valid", bus.rsp1_valid, e.own);
                chk("rsp_res", bus.rsp_res, e.res);
                chk("rsp_zero", bus.rsp_zero, e.z);
                chk("rsp_neg", bus.rsp_neg, e.n);
                chk("rsp_ovf", bus.rsp_ovf, e.o);
                chk("ovf_cnt", bus.ovf_cnt, e.cnt);
                if (e.own ? bus.rsp1_ready : bus.rsp0_ready) void'(q.pop_front());
            end else begin
                chk("rsp0_valid_idle", bus.rsp0_valid, 1'b0);
                chk("rsp1_valid_idle", bus.rsp1_valid, 1'b0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_req(input int r, input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] f, input logic im);
        if (r == 0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_af = f; bus.req0_i = im;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_af = f; bus.req1_i = im;
        end
    endtask

    task automatic wait_acc(input int r);
        bit ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if ((r == 0 && acc0) || (r == 1 && acc1)) begin ok = 1'b1; break; end
        end
        chk("accept_timeout", ok, 1'b1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (q.size() == 0) break;
        end
        chk("idle_timeout", (q.size() == 0), 1'b1);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h7FFFFFFF;
            1: return 32'h80000000;
            2: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    task automatic step_req(input int r);
        logic acc, v;
        acc = (r == 0) ? acc0 : acc1;
        v   = (r == 0) ? bus.req0_valid : bus.req1_valid;
        if (acc || (!v && $urandom_range(0, 2) == 0)) begin
            v = acc ? logic'($urandom_range(0, 1)) : 1'b1;
            set_req(r, v, rnd_val(), rnd_val(), 4'($urandom_range(0, 7)), logic'($urandom_range(0, 1)));
        end
    endtask

    initial begin : stim
        logic [3:0] g;
        int         n;
        bit         ok;
        set_req(0, 1'b0, 0, 0, 0, 1'b0);
        set_req(1, 1'b0, 0, 0, 0, 1'b0);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        bus2.req0_valid = 1'b0; bus2.req0_a = 32'h7FFFFFFF; bus2.req0_b = 32'h1;
        bus2.req0_af = 4'd0; bus2.req0_i = 1'b0;
        bus2.req1_valid = 1'b0; bus2.req1_a = 0; bus2.req1_b = 0; bus2.req1_af = 0; bus2.req1_i = 1'b0;
        bus2.rsp0_ready = 1'b1;
        bus2.rsp1_ready = 1'b1;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        chk("rst_SrcA", bus.SrcA, 0);
        chk("rst_SrcB", bus.SrcB, 0);
        chk("rst_af", bus.af, 0);
        chk("rst_i", bus.i, 0);
        chk("rst_res", bus.rsp_res, 0);
        chk("rst_flags", {bus.rsp_zero, bus.rsp_neg, bus.rsp_ovf}, 0);
        chk("rst_ovf_cnt", bus.ovf_cnt, 0);
        chk("rst_busy", bus.busy, 0);

        // Tie from reset: grants must alternate 0,1,0,1.
        set_req(0, 1'b1, 32'd3, 32'd1, 4'd2, 1'b0);
        set_req(1, 1'b1, 32'd4, 32'd2, 4'd0, 1'b1);
        g = 4'h0; n = 0;
        for (int k = 0; k < 60 && n < 4; k++) begin
            @(negedge clk); #2;
            if (bus.req0_ready || bus.req1_ready) begin g[n] = bus.req1_ready; n++; end
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("grant_count", n, 4);
        chk("grant_seq", g, 4'b1010);
        wait_idle();

        // Single op with operand visibility in EXEC.
        set_req(0, 1'b1, 32'd1, 32'd2, 4'd0, 1'b0);
        wait_acc(0);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("exec_SrcA", bus.SrcA, 32'd1);
        chk("exec_SrcB", bus.SrcB, 32'd2);
        chk("exec_af", bus.af, 4'd0);
        wait_idle();

        // Backpressure with the other requester waiting.
        bus.rsp0_ready = 1'b0;
        set_req(0, 1'b1, 32'd5, 32'd6, 4'd6, 1'b0);
        wait_acc(0);
        bus.req0_valid = 1'b0;
        set_req(1, 1'b1, 32'd9, 32'd1, 4'd2, 1'b0);
        tick(7);
        bus.rsp0_ready = 1'b1;
        wait_acc(1);
        bus.req1_valid = 1'b0;
        wait_idle();

        // Signed overflow and negative result.
        set_req(0, 1'b1, 32'h7FFFFFFF, 32'd1, 4'd0, 1'b0);
        wait_acc(0);
        bus.req0_valid = 1'b0;
        wait_idle();
        chk("ovf_cnt_inc", bus.ovf_cnt, 8'd1);

        // Reset while the operation is in EXEC drops it.
        set_req(0, 1'b1, 32'h7FFFFFFF, 32'd1, 4'd0, 1'b0);
        wait_acc(0);
        bus.req0_valid = 1'b0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("rstx_busy", bus.busy, 0);
        chk("rstx_ovf_cnt", bus.ovf_cnt, 0);
        chk("rstx_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 0);
        set_req(0, 1'b1, 32'd7, 32'd7, 4'd2, 1'b0);
        set_req(1, 1'b1, 32'd8, 32'd8, 4'd5, 1'b0);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #2;
            if (bus.req0_ready || bus.req1_ready) begin ok = 1'b1; break; end
        end
        chk("rstx_tie_r0", {ok, bus.req0_ready, bus.req1_ready}, 3'b110);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        wait_acc(1);
        bus.req1_valid = 1'b0;
        wait_idle();

        // Narrow counter saturates at 3.
        for (int k = 1; k <= 5; k++) begin
            bus2.req0_valid = 1'b1;
            ok = 1'b0;
            for (int w = 0; w < 20; w++) begin
                @(negedge clk);
                if (bus2.req0_ready) begin ok = 1'b1; break; end
            end
            chk("sat_accept", ok, 1'b1);
            @(posedge clk); #1;
            bus2.req0_valid = 1'b0;
            tick(3);
            chk("sat_ovf_cnt", bus2.ovf_cnt, (k > 3) ? 3 : k);
        end

        // Randomised traffic with random response backpressure.
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            step_req(0);
            step_req(1);
            bus.rsp0_ready = ($urandom_range(0, 3) != 0);
            bus.rsp1_ready = ($urandom_range(0, 3) != 0);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        wait_idle();
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
